// File: rtl/cordic_fp_pkg.sv
// Shared constants, FSM encoding and float field helpers for the CORDIC
// floating-point gain compensation block.
package cordic_fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int K_W   = 24;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_INF  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_X,
        ST_MUL_Y,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_fields_t;

    function automatic fp_fields_t fp_split(input logic [FP_W-1:0] f);
        fp_fields_t r;
        r.sign = f[FP_W-1];
        r.exp  = f[FP_W-2 -: EXP_W];
        r.man  = f[MAN_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/cordic_fp_mant_scale.sv
// Combinational float * K (Q0.24) with truncation, zero/denormal flush,
// Inf/NaN passthrough and exponent-underflow flush.
module cordic_fp_mant_scale
    import cordic_fp_pkg::*;
(
    input  logic [FP_W-1:0] f_in,
    input  logic [K_W-1:0]  k,
    output logic [FP_W-1:0] f_out
);

    fp_fields_t         fld;
    logic [2*K_W-1:0]   prod;

    assign fld  = fp_split(f_in);
    assign prod = {{K_W{1'b0}}, 1'b1, fld.man} * {{K_W{1'b0}}, k};

    always_comb begin
        f_out = {fld.sign, {(FP_W-1){1'b0}}};
        if (fld.exp == EXP_ZERO) begin
            f_out = {fld.sign, {(FP_W-1){1'b0}}};
        end else if (fld.exp == EXP_INF) begin
            f_out = f_in;
        end else if (prod[2*K_W-1]) begin
            f_out = {fld.sign, fld.exp, prod[2*K_W-2 -: MAN_W]};
        end else if (fld.exp == EXP_W'(1)) begin
            // Decrementing exponent 1 would land in the denormal range; flush instead.
            f_out = {fld.sign, {(FP_W-1){1'b0}}};
        end else begin
            f_out = {fld.sign, fld.exp - EXP_W'(1), prod[2*K_W-3 -: MAN_W]};
        end
    end

endmodule

// File: rtl/cordic_floatingpoint_gain_comp.sv
// Removes CORDIC gain from X and Y by multiplying each with K, sharing one
// mantissa multiplier across two sequential states.
module cordic_floatingpoint_gain_comp
    import cordic_fp_pkg::*;
(
    input  logic            iClk,
    input  logic            iRst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] x_in,
    input  logic [FP_W-1:0] y_in,
    input  logic [K_W-1:0]  k_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] x_out,
    output logic [FP_W-1:0] y_out
);

    state_t          state;
    logic [FP_W-1:0] x_r, y_r;
    logic [K_W-1:0]  k_r;
    logic [FP_W-1:0] op, scaled;

    assign op = (state == ST_MUL_Y) ? y_r : x_r;

    cordic_fp_mant_scale u_scale (
        .f_in  (op),
        .k     (k_r),
        .f_out (scaled)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            x_r       <= '0;
            y_r       <= '0;
            k_r       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid && in_ready) begin
                    x_r      <= x_in;
                    y_r      <= y_in;
                    k_r      <= k_in;
                    in_ready <= 1'b0;
                    state    <= ST_MUL_X;
                end
                ST_MUL_X: begin
                    x_out <= scaled;
                    state <= ST_MUL_Y;
                end
                ST_MUL_Y: begin
                    y_out     <= scaled;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_floatingpoint_gain_comp.sv
// Directed and random checks of the gain compensation block against a
// plain-arithmetic float scaling model.
module tb_cordic_floatingpoint_gain_comp;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic [23:0] k_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] x_out;
    logic [31:0] y_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iClk = ~iClk;

    cordic_floatingpoint_gain_comp dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .k_in      (k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_scale(input logic [31:0] f, input logic [23:0] k);
        int unsigned       s, e, m, mant, ne;
        longint unsigned   p;
        s = f[31];
        e = f[30:23];
        m = f[22:0];
        if (e == 0)   return {f[31], 31'b0};
        if (e == 255) return f;
        p = (longint'(1) * (64'd8388608 + m)) * k;
        if (p >= 64'd140737488355328) begin
            mant = int'((p / 64'd16777216) % 64'd8388608);
            ne   = e;
        end else begin
            if (e == 1) return {f[31], 31'b0};
            mant = int'((p / 64'd8388608) % 64'd8388608);
            ne   = e - 1;
        end
        return {s[0], ne[7:0], mant[22:0]};
    endfunction

    // One full transaction; hold = cycles out_ready stays low after out_valid.
    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [23:0] k,
                           input int hold, input bit poke);
        logic [31:0] ex, ey;
        int n;
        ex = ref_scale(x, k);
        ey = ref_scale(y, k);
        @(negedge iClk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; x_in = x; y_in = y; k_in = k;
        @(posedge iClk);
        @(negedge iClk);
        in_valid = poke;
        x_in = $urandom; y_in = $urandom; k_in = 24'($urandom);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        n = 1;
        while (!out_valid && n < 12) begin
            @(negedge iClk);
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("x_out", x_out, ex);
        chk("y_out", y_out, ey);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_x", x_out, ex);
            chk("hold_y", y_out, ey);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic [23:0] rk;
        logic [7:0]  ee;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x_out", x_out, 32'h0);
        chk("rst_y_out", y_out, 32'h0);
        @(negedge iClk);
        iRst = 1'b0;

        // Directed vectors with hand-derived constants
        run_txn(32'h3F800000, 32'hC0000000, 24'h9B74ED, 0, 1'b0);
        chk("basic_x_const", x_out, 32'h3F1B74ED);
        chk("basic_y_const", y_out, 32'hBF9B74ED);
        run_txn(32'h00000000, 32'h7F800000, 24'h9B74ED, 0, 1'b0);
        chk("spec_x_const", x_out, 32'h00000000);
        chk("spec_y_const", y_out, 32'h7F800000);
        run_txn(32'h80800000, 32'h00400000, 24'h9B74ED, 0, 1'b0);
        chk("uflow_x_const", x_out, 32'h80000000);
        chk("uflow_y_const", y_out, 32'h00000000);
        run_txn(32'h3FFFFFFF, 32'h7FC00001, 24'hFFFFFF, 0, 1'b0);
        chk("noshift_x_const", x_out, 32'h3FFFFFFE);
        chk("nan_y_const", y_out, 32'h7FC00001);
        // Backpressure with a stray in_valid that must be ignored
        run_txn(32'h40490FDB, 32'hBF000000, 24'h9B74ED, 5, 1'b1);

        // Mid-operation reset during MUL_Y
        @(negedge iClk);
        in_valid = 1'b1; x_in = 32'h3F800000; y_in = 32'h3F800000; k_in = 24'h9B74ED;
        @(posedge iClk);
        @(negedge iClk);
        in_valid = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_x_out", x_out, 32'h0);
        chk("mrst_y_out", y_out, 32'h0);
        @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
            chk("mrst_in_ready", 32'(in_ready), 32'd1);
        end

        // Random transactions, biased towards boundary exponents
        for (int t = 0; t < 60; t++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ee = 8'd0;
                1: ee = 8'd1;
                2: ee = 8'd255;
                3: ee = 8'd2;
                default: ee = 8'($urandom_range(3, 254));
            endcase
            rx[30:23] = ee;
            rk = 24'($urandom);
            if ($urandom_range(0, 7) != 0) rk[23] = 1'b1;
            run_txn(rx, ry, rk, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
